// File: rtl/pulse_train_tx.sv
//==============================================================================
// pulse_train_tx : emits exactly N clean high/low pulses per accepted request.
// Optional abort feature: PULSE_TRAIN_ABORT_EN.               Rev 1.0
//==============================================================================
`default_nettype none

module pulse_train_tx #(
    parameter int CNT_W    = 8,
    parameter int HIGH_CYC = 1,
    parameter int LOW_CYC  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_count,
`ifdef PULSE_TRAIN_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             req_ready,
    output logic             aout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    localparam int PH_MAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int PH_W   = $clog2(PH_MAX) + 1;
    localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(HIGH_CYC - 1);
    localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(LOW_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [PH_W-1:0]  phase;
    logic [PH_W-1:0]  phase_nx;
    logic [CNT_W-1:0] remaining_nx;
    logic             done_nx;
    logic             aout_nx;
    logic             busy_nx;
    logic             ready_nx;
    logic             accept;

    assign accept = req_valid && req_ready;

`ifdef PULSE_TRAIN_ABORT_EN
    logic aborted_nx;
    logic abort_hit;

    assign abort_hit = abort && (state != IDLE);
`endif

    always_comb begin
        state_nx     = state;
        phase_nx     = phase;
        remaining_nx = remaining;
        done_nx      = 1'b0;
`ifdef PULSE_TRAIN_ABORT_EN
        aborted_nx   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_count == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx     = HIGH;
                        phase_nx     = '0;
                        remaining_nx = req_count;
                    end
                end
            end
            HIGH: begin
                // Pulse counts as completed once its high phase ends.
                if (phase == HIGH_LAST) begin
                    state_nx     = LOW;
                    phase_nx     = '0;
                    remaining_nx = remaining - CNT_W'(1);
                end else begin
                    phase_nx = phase + PH_W'(1);
                end
            end
            LOW: begin
                if (phase == LOW_LAST) begin
                    phase_nx = '0;
                    if (remaining != '0) begin
                        state_nx = HIGH;
                    end else begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end else begin
                    phase_nx = phase + PH_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                phase_nx = '0;
            end
        endcase
`ifdef PULSE_TRAIN_ABORT_EN
        // Abort overrides everything, including a coincident completion.
        if (abort_hit) begin
            state_nx     = IDLE;
            phase_nx     = '0;
            remaining_nx = remaining;
            done_nx      = 1'b0;
            aborted_nx   = 1'b1;
        end
`endif
        aout_nx  = (state_nx == HIGH);
        busy_nx  = (state_nx != IDLE);
        ready_nx = (state_nx == IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            remaining <= '0;
            done      <= 1'b0;
            aout      <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            state     <= state_nx;
            phase     <= phase_nx;
            remaining <= remaining_nx;
            done      <= done_nx;
            aout      <= aout_nx;
            busy      <= busy_nx;
            req_ready <= ready_nx;
        end
    end

`ifdef PULSE_TRAIN_ABORT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aborted <= 1'b0;
        end else begin
            aborted <= aborted_nx;
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/pulse_train_tx.md
Name: pulse_train_tx

Overview:
- Transmitter side of the single-wire rising-edge pulse protocol: on request, emits exactly N clean pulses on one serial line, so a downstream Mealy edge detector counts exactly N rising edges.
- Sits between control logic (valid/ready request of a pulse count) and the serial line feeding the edge detector.
- Fully synchronous Moore design: all outputs are registered and change on the posedge of clock only.

Parameters:
- CNT_W, 8, width of the requested pulse count and of the remaining counter.
- HIGH_CYC, 1, cycles aout is held high per pulse; legal range >=1.
- LOW_CYC, 1, cycles aout is held low after each pulse; legal range >=1.

Ports:
- clock  in  1  system clock, posedge only
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request strobe
- req_count  in  CNT_W  number of pulses to emit; sampled on handshake
- req_ready  out  1  high only in IDLE
- aout  out  1  serial pulse line
- busy  out  1  high while a train is in progress
- done  out  1  one-cycle completion pulse
- remaining  out  CNT_W  pulses not yet completed

Behaviour:
- Reset: reset, asynchronous, active-high; clock clock. While reset=1 the block is in IDLE with:
  - aout=0, busy=0, done=0, remaining=0, phase counter=0.
  - req_ready=0 during reset; req_ready=1 from the first edge after release.
- States are IDLE, HIGH and LOW. The phase counter width is $clog2(max(HIGH_CYC,LOW_CYC))+1.
- IDLE:
  - req_ready=1, aout=0, busy=0.
  - Handshake occurs when req_valid and req_ready are both high at a posedge.
  - If req_count==0: stay in IDLE, assert done=1 in the next cycle, and emit no pulse.
  - If req_count>0: next state is HIGH, remaining<=req_count, aout<=1, busy<=1.
- HIGH:
  - aout=1 for exactly HIGH_CYC cycles.
  - On the last of these cycles: remaining<=remaining-1 and the next state is LOW.
- LOW:
  - aout=0 for exactly LOW_CYC cycles.
  - On the last of these cycles: if remaining>0, go to HIGH; else go to IDLE and assert done for one cycle.
- Latency and throughput:
  - aout rises in the cycle after the handshake.
  - busy lasts exactly N*(HIGH_CYC+LOW_CYC) cycles.
  - done is asserted in the first IDLE cycle, concurrent with req_ready=1.
- Back-to-back operation: a request presented during the done cycle is accepted. The line therefore always shows at least LOW_CYC low cycles before any rising edge.
- req_valid and req_count are ignored while busy; no queuing.
- remaining never wraps below 0. A req_count of 2^CNT_W-1 is legal.
- Reset mid-train: aout drops to 0 immediately (asynchronously), the train is discarded, and no done is asserted.
- No glitches: aout changes only at posedge clock.

Optional Feature:
- Macro: PULSE_TRAIN_ABORT_EN.
- With the macro defined:
  - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 at a posedge while busy: the next state is IDLE, aout<=0, busy<=0, and aborted=1 for one cycle instead of done.
  - remaining holds its value at the abort so software can read pulses not sent. An abort during HIGH does not decrement remaining.
  - abort in IDLE has no effect.
  - If abort and the final LOW-phase cycle coincide, abort wins: aborted=1 and done=0.
- Without the macro: no abort or aborted ports; the logic is absent.

Test Plan:
- HIGH_CYC=2, LOW_CYC=1, req_count=3 accepted at edge E0:
  - aout=1 in cycles 1-2, 4-5 and 7-8; aout=0 in cycles 3, 6 and 9.
  - busy covers cycles 1-9; done=1 only in cycle 10; remaining steps 3,2,1,0 at the ends of cycles 2, 5 and 8.
- req_count=0:
  - aout stays 0 and busy stays 0.
  - done=1 in the cycle after the handshake; req_ready stays 1.
- req_valid held high continuously, counts 2 then 1 (defaults H=L=1):
  - Second request is accepted in the done cycle of the first.
  - Exactly 3 rising edges total, each preceded by >=1 low cycle.
  - req_ready=0 throughout both trains.
- req_count=5, reset asserted mid-way through cycle 4 (asynchronously):
  - aout=0 immediately; done never asserts.
  - After release, a new request of 1 yields exactly one pulse.
- CNT_W=8, req_count=255, H=L=1:
  - Exactly 255 rising edges; busy lasts 510 cycles; remaining ends at 0 with no wrap.
- PULSE_TRAIN_ABORT_EN, req_count=4, H=L=1, abort at the 3rd HIGH cycle:
  - aout=0 in the next cycle; aborted=1 for one cycle; done=0; remaining=2.
